// File: rtl/multicycle_control_pkg.sv
// Shared control definitions for the multi-cycle RV32I sequencer:
// opcode constants (also used by the immediate generator), state encoding,
// datapath mux/select codes and the per-state control word.
package riscv_ctrl_pkg;

    // Opcode field values (instruction[6:0])
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_I_LD = 7'b0000011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_SB   = 7'b1100011;
    localparam logic [6:0] OP_J    = 7'b1101111;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC_R,
        ST_EXEC_I,
        ST_MEM_ADDR,
        ST_MEM_RD,
        ST_MEM_WR,
        ST_WB_ALU,
        ST_WB_MEM,
        ST_BRANCH,
        ST_JAL,
        ST_TRAP
    } state_t;

    // Immediate-format select
    localparam logic [2:0] IMM_I    = 3'd0;
    localparam logic [2:0] IMM_S    = 3'd1;
    localparam logic [2:0] IMM_SB   = 3'd2;
    localparam logic [2:0] IMM_J    = 3'd3;
    localparam logic [2:0] IMM_NONE = 3'd7;

    // ALU operand A select
    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_OLDPC = 2'd1;
    localparam logic [1:0] SRCA_RS1   = 2'd2;

    // ALU operand B select
    localparam logic [1:0] SRCB_RS2  = 2'd0;
    localparam logic [1:0] SRCB_IMM  = 2'd1;
    localparam logic [1:0] SRCB_FOUR = 2'd2;

    // ALU operation class
    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_CMP   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    // Register-file write data select
    localparam logic [1:0] RES_ALUOUT = 2'd0;
    localparam logic [1:0] RES_MEM    = 2'd1;
    localparam logic [1:0] RES_PC4    = 2'd2;

    // Moore part of the control outputs, registered alongside the state
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       addr_src;
        logic       pc_src;
        logic       reg_write;
        logic [2:0] imm_sel;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] result_src;
        logic       illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_RESET = '{imm_sel: IMM_NONE, default: '0};

    // Control word for a given state; is_store only matters in MEM_ADDR
    function automatic ctrl_t state_ctrl(input state_t s, input logic is_store);
        ctrl_t c;
        c = CTRL_RESET;
        case (s)
            ST_FETCH: begin
                c.mem_req   = 1'b1;
                c.addr_src  = 1'b0;
                c.alu_src_a = SRCA_PC;
                c.alu_src_b = SRCB_FOUR;
                c.alu_op    = ALU_ADD;
            end
            ST_DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALU_ADD;
            end
            ST_EXEC_R: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_RS2;
                c.alu_op    = ALU_FUNCT;
            end
            ST_EXEC_I: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
                c.imm_sel   = IMM_I;
                c.alu_op    = ALU_FUNCT;
            end
            ST_MEM_ADDR: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALU_ADD;
                c.imm_sel   = is_store ? IMM_S : IMM_I;
            end
            ST_MEM_RD: begin
                c.mem_req  = 1'b1;
                c.addr_src = 1'b1;
            end
            ST_MEM_WR: begin
                c.mem_req  = 1'b1;
                c.mem_we   = 1'b1;
                c.addr_src = 1'b1;
            end
            ST_WB_ALU: begin
                c.reg_write  = 1'b1;
                c.result_src = RES_ALUOUT;
            end
            ST_WB_MEM: begin
                c.reg_write  = 1'b1;
                c.result_src = RES_MEM;
            end
            ST_BRANCH: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_RS2;
                c.alu_op    = ALU_CMP;
                c.pc_src    = 1'b1;
            end
            ST_JAL: begin
                c.pc_src     = 1'b1;
                c.reg_write  = 1'b1;
                c.result_src = RES_PC4;
            end
            ST_TRAP: begin
                c.illegal = 1'b1;
            end
            default: c = CTRL_RESET;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Memory port handshake between the sequencer (master) and memory (slave).
// Handshake: mem_req is valid and mem_ready is ready; a request completes on
// a cycle where both are 1. While mem_req=1 and mem_ready=0 the master holds
// mem_req, mem_we and addr_src unchanged. mem_ready has no meaning while
// mem_req=0 and the master ignores it then.
interface multicycle_control_if;
    logic mem_req;
    logic mem_we;
    logic addr_src;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output addr_src,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  addr_src,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_control_opcode_class_decode.sv
// Combinational opcode classifier used in DECODE: picks the state that
// follows DECODE and the immediate format the datapath should build.
module opcode_class_decode
    import riscv_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 7
) (
    input  logic [OPCODE_W-1:0] opcode,
    output state_t              next_state,
    output logic [2:0]          imm_sel,
    output logic                is_store
);

    // Opcode lookup; unknown opcodes route to TRAP
    always_comb begin
        next_state = ST_TRAP;
        imm_sel    = IMM_NONE;
        is_store   = 1'b0;
        case (opcode)
            OP_R: begin
                next_state = ST_EXEC_R;
                imm_sel    = IMM_NONE;
            end
            OP_I: begin
                next_state = ST_EXEC_I;
                imm_sel    = IMM_I;
            end
            OP_I_LD: begin
                next_state = ST_MEM_ADDR;
                imm_sel    = IMM_I;
            end
            OP_S: begin
                next_state = ST_MEM_ADDR;
                imm_sel    = IMM_S;
                is_store   = 1'b1;
            end
            OP_SB: begin
                next_state = ST_BRANCH;
                imm_sel    = IMM_SB;
            end
            OP_J: begin
                next_state = ST_JAL;
                imm_sel    = IMM_J;
            end
            default: begin
                next_state = ST_TRAP;
                imm_sel    = IMM_NONE;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main sequencer for the multi-cycle RV32I core. Walks fetch, decode,
// execute, memory and writeback over several clocks with one shared ALU and
// one memory port. Most outputs are registered alongside the state; the few
// that depend on mem_ready / branch_cond in the current cycle (ir_write,
// pc_write, instr_done) and the DECODE immediate select are combinational.
// Optional build macro MC_PERF_COUNT_EN adds cycle/retired-instruction
// counters.
module multicycle_control
    import riscv_ctrl_pkg::*;
#(
    parameter int OPCODE_W   = 7,
    parameter int WAIT_LIMIT = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                branch_cond,
    multicycle_control_if.master mem,
    output logic                ir_write,
    output logic                pc_write,
    output logic                pc_src,
    output logic                reg_write,
    output logic [2:0]          imm_sel,
    output logic [1:0]          alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic [1:0]          result_src,
    output logic                instr_done,
    output logic                illegal,
    output logic                mem_timeout,
`ifdef MC_PERF_COUNT_EN
    output logic [31:0]         cycle_count,
    output logic [31:0]         instret_count,
`endif
    output state_t              state_dbg
);

    // Last wait-counter value before the bound trips (unused when 0)
    localparam logic [31:0] WAIT_LAST = 32'(WAIT_LIMIT - 1);

    state_t      state;
    state_t      state_n;
    ctrl_t       ctrl_q;
    ctrl_t       ctrl_n;
    logic        is_store_q;
    logic        is_store_n;
    state_t      dec_next;
    logic [2:0]  dec_imm;
    logic        dec_store;
    logic [31:0] wait_cnt;
    logic        mem_ack;
    logic        req_wait;
    logic        timeout_hit;

    opcode_class_decode #(
        .OPCODE_W (OPCODE_W)
    ) u_opcode_class_decode (
        .opcode     (opcode),
        .next_state (dec_next),
        .imm_sel    (dec_imm),
        .is_store   (dec_store)
    );

    // mem_ready only counts while a request is actually outstanding
    assign mem_ack     = mem.mem_req & mem.mem_ready;
    assign req_wait    = mem.mem_req & ~mem.mem_ready;
    assign timeout_hit = (WAIT_LIMIT > 0) && req_wait && (wait_cnt == WAIT_LAST);

    // Next-state selection and the control word that goes with it
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:     state_n = ST_FETCH;
            ST_FETCH: begin
                if (mem_ack)          state_n = ST_DECODE;
                else if (timeout_hit) state_n = ST_TRAP;
            end
            ST_DECODE:   state_n = dec_next;
            ST_EXEC_R:   state_n = ST_WB_ALU;
            ST_EXEC_I:   state_n = ST_WB_ALU;
            ST_MEM_ADDR: state_n = is_store_q ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD: begin
                if (mem_ack)          state_n = ST_WB_MEM;
                else if (timeout_hit) state_n = ST_TRAP;
            end
            ST_MEM_WR: begin
                if (mem_ack)          state_n = ST_FETCH;
                else if (timeout_hit) state_n = ST_TRAP;
            end
            ST_WB_ALU:   state_n = ST_FETCH;
            ST_WB_MEM:   state_n = ST_FETCH;
            ST_BRANCH:   state_n = ST_FETCH;
            ST_JAL:      state_n = ST_FETCH;
            ST_TRAP:     state_n = ST_TRAP;
            default:     state_n = ST_IDLE;
        endcase
        // Load/store class is captured in DECODE while the opcode is valid
        is_store_n = (state == ST_DECODE) ? dec_store : is_store_q;
        ctrl_n     = state_ctrl(state_n, is_store_n);
    end

    // Sequencer state, registered Moore outputs and sticky timeout flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            ctrl_q      <= CTRL_RESET;
            is_store_q  <= 1'b0;
            mem_timeout <= 1'b0;
        end else begin
            state      <= state_n;
            ctrl_q     <= ctrl_n;
            is_store_q <= is_store_n;
            if (timeout_hit) begin
                mem_timeout <= 1'b1;
            end
        end
    end

    // Consecutive wait cycles of the current request; clears on completion
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (req_wait) begin
            wait_cnt <= wait_cnt + 32'd1;
        end else begin
            wait_cnt <= '0;
        end
    end

`ifdef MC_PERF_COUNT_EN
    // Performance counters, wrapping naturally at 2^32
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_count   <= '0;
            instret_count <= '0;
        end else begin
            if (state != ST_IDLE && state != ST_TRAP) begin
                cycle_count <= cycle_count + 32'd1;
            end
            if (instr_done) begin
                instret_count <= instret_count + 32'd1;
            end
        end
    end
`endif

    assign mem.mem_req  = ctrl_q.mem_req;
    assign mem.mem_we   = ctrl_q.mem_we;
    assign mem.addr_src = ctrl_q.addr_src;
    assign pc_src       = ctrl_q.pc_src;
    assign reg_write    = ctrl_q.reg_write;
    assign alu_src_a    = ctrl_q.alu_src_a;
    assign alu_src_b    = ctrl_q.alu_src_b;
    assign alu_op       = ctrl_q.alu_op;
    assign result_src   = ctrl_q.result_src;
    assign illegal      = ctrl_q.illegal;
    assign state_dbg    = state;

    // DECODE needs the freshly loaded opcode, so its immediate is combinational
    assign imm_sel    = (state == ST_DECODE) ? dec_imm : ctrl_q.imm_sel;
    assign ir_write   = (state == ST_FETCH) & mem_ack;
    assign pc_write   = ir_write
                      | ((state == ST_BRANCH) & branch_cond)
                      | (state == ST_JAL);
    assign instr_done = ((state == ST_MEM_WR) & mem_ack)
                      | (state == ST_WB_ALU)
                      | (state == ST_WB_MEM)
                      | (state == ST_BRANCH)
                      | (state == ST_JAL);

endmodule
